// File: rtl/sp_if_ctrl_ddr_seq.sv
// ---------------------------------------------------------------------------
// sp_if_ctrl_ddr_seq
// DDR access sequencer for the signal-processing interface. A start pulse
// walks an external order table (one 64-bit entry per access). Each entry is
// fetched, loaded into the access descriptor and handed to the DDR access
// engine. Read entries also wait for signal processing to finish before the
// next entry is fetched. A watchdog aborts a stalled access. Overrun is
// flagged for a start while busy or when the order table runs out.
//
// Ports:
//   i_clk156m          system clock
//   i_srst_n           synchronous active-low reset
//   i_frame_max        frame counter terminal value (0-origin)
//   i_frame_offset     per-channel per-frame offset step (32 bits each)
//   i_ram_base         per-channel base address (32 bits each)
//   i_ctrl_startp      sequence start pulse
//   i_skip_tx          suppress o_ctrl_endp for this sequence (latched at start)
//   i_sp_end           signal-processing complete pulse
//   i_ddr_endp         DDR access complete pulse
//   i_rxfifo_rd_last   last DDR read beat
//   o_ord_rden/addr    order memory read port, i_ord_data returns the entry
//   o_frame_time       frame counter
//   o_ram_offset_addr  per-channel frame_time*offset+base
//   o_ddr_*            access descriptor, request level and start pulses
//   o_sp_start         signal-processing start (i_rxfifo_rd_last delayed)
//   o_ddr_endp         write access complete pulse
//   o_ctrl_endp        sequence complete, transmit request
//   o_busy             sequence in progress
//   o_err_timeout      watchdog expired pulse
//   o_err_ovr          start while busy / order table exhausted pulse
// ---------------------------------------------------------------------------
module sp_if_ctrl_ddr_seq #(
    parameter int NUM_RAM = 2,
    parameter int FRM_W   = 4,
    parameter int ORD_AW  = 10,
    parameter int RD_LAT  = 2,
    parameter int TO_W    = 20
) (
    input  logic                   i_clk156m,
    input  logic                   i_srst_n,
    input  logic [FRM_W-1:0]       i_frame_max,
    input  logic [NUM_RAM*32-1:0]  i_frame_offset,
    input  logic [NUM_RAM*32-1:0]  i_ram_base,
    input  logic                   i_ctrl_startp,
    input  logic                   i_skip_tx,
    input  logic                   i_sp_end,
    input  logic                   i_ddr_endp,
    input  logic                   i_rxfifo_rd_last,
    output logic                   o_ord_rden,
    output logic [ORD_AW-1:0]      o_ord_addr,
    input  logic [63:0]            i_ord_data,
    output logic [FRM_W-1:0]       o_frame_time,
    output logic [NUM_RAM*32-1:0]  o_ram_offset_addr,
    output logic                   o_ddr_wxr,
    output logic [3:0]             o_ddr_area,
    output logic [26:0]            o_ddr_addr,
    output logic [31:0]            o_ddr_size,
    output logic                   o_ddr_start,
    output logic                   o_ddr_rd_startp,
    output logic                   o_ddr_wr_startp,
    output logic                   o_sp_start,
    output logic                   o_ddr_endp,
    output logic                   o_ctrl_endp,
    output logic                   o_busy,
    output logic                   o_err_timeout,
    output logic                   o_err_ovr
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        LOAD,
        ACCESS,
        WAIT_SP
    } state_t;

    // The watchdog fires on the ACCESS cycle in which the counter steps onto
    // its all-ones terminal value, i.e. while it still holds all-ones minus 1.
    localparam logic [TO_W-1:0] WDOG_LAST = ~(TO_W'(1));
    localparam logic [1:0]      RD_LAST   = 2'(RD_LAT - 1);

    state_t              state;
    state_t              next_state;
    logic [ORD_AW-1:0]   ord_ptr;
    logic [1:0]          rd_cnt;
    logic [TO_W-1:0]     wdog;
    logic                desc_last;
    logic                skip_latched;
    logic                rd_done;
    logic                wdog_expire;
    logic                ptr_at_max;
    logic                start_accept;
    logic                ptr_inc;
    logic                ptr_ovr;
    logic                timeout_event;
    logic                wr_done;
    logic [31:0]         prod [NUM_RAM];
    logic                unused_rsvd;

    assign rd_done     = (rd_cnt == RD_LAST);
    assign wdog_expire = (wdog == WDOG_LAST);
    assign ptr_at_max  = &ord_ptr;
    assign wr_done     = (state == ACCESS) && i_ddr_endp && o_ddr_wxr;

    assign o_ord_rden  = (state == FETCH);
    assign o_ord_addr  = ord_ptr;
    assign o_ddr_start = (state == ACCESS);
    assign o_busy      = (state != IDLE);

    // Reserved entry bits carry no meaning.
    assign unused_rsvd = ^i_ord_data[2:0];

    // State register.
    always_ff @(posedge i_clk156m) begin
        if (!i_srst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. Moving on to another entry is refused when the
    // pointer already sits on the last table address; that is an overrun.
    // i_ddr_endp wins over a watchdog expiry in the same cycle.
    always_comb begin
        next_state    = state;
        start_accept  = 1'b0;
        ptr_inc       = 1'b0;
        ptr_ovr       = 1'b0;
        timeout_event = 1'b0;
        case (state)
            IDLE: begin
                if (i_ctrl_startp) begin
                    start_accept = 1'b1;
                    next_state   = FETCH;
                end
            end
            FETCH: begin
                next_state = WAIT_RD;
            end
            WAIT_RD: begin
                if (rd_done) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (i_ddr_endp) begin
                    if (!o_ddr_wxr) begin
                        next_state = WAIT_SP;
                    end else if (desc_last) begin
                        next_state = IDLE;
                    end else if (ptr_at_max) begin
                        ptr_ovr    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        ptr_inc    = 1'b1;
                        next_state = FETCH;
                    end
                end else if (wdog_expire) begin
                    timeout_event = 1'b1;
                    next_state    = IDLE;
                end
            end
            WAIT_SP: begin
                if (i_sp_end) begin
                    if (desc_last) begin
                        next_state = IDLE;
                    end else if (ptr_at_max) begin
                        ptr_ovr    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        ptr_inc    = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Sequence bookkeeping: order pointer, read-latency counter, watchdog,
    // skip flag and frame counter. The frame counter resets to its terminal
    // value so that the first accepted start produces frame 0.
    always_ff @(posedge i_clk156m) begin
        if (!i_srst_n) begin
            ord_ptr      <= '0;
            rd_cnt       <= '0;
            wdog         <= '0;
            skip_latched <= 1'b0;
            o_frame_time <= i_frame_max;
        end else begin
            if (start_accept) begin
                ord_ptr      <= '0;
                skip_latched <= i_skip_tx;
                o_frame_time <= (o_frame_time == i_frame_max) ? '0
                                : o_frame_time + FRM_W'(1);
            end else if (ptr_inc) begin
                ord_ptr <= ord_ptr + ORD_AW'(1);
            end
            rd_cnt <= (state == WAIT_RD) ? rd_cnt + 2'd1 : 2'd0;
            if (state == LOAD) begin
                wdog <= '0;
            end else if (state == ACCESS) begin
                wdog <= wdog + TO_W'(1);
            end
        end
    end

    // Descriptor capture. The entry is on i_ord_data during the last
    // WAIT_RD cycle, so it is registered on the edge into LOAD and is stable
    // from LOAD onwards.
    always_ff @(posedge i_clk156m) begin
        if (!i_srst_n) begin
            desc_last  <= 1'b0;
            o_ddr_wxr  <= 1'b0;
            o_ddr_area <= '0;
            o_ddr_addr <= '0;
            o_ddr_size <= '0;
        end else if ((state == WAIT_RD) && rd_done) begin
            desc_last  <= i_ord_data[63];
            o_ddr_wxr  <= i_ord_data[62];
            o_ddr_area <= i_ord_data[61:58];
            o_ddr_addr <= i_ord_data[57:31];
            o_ddr_size <= {i_ord_data[30:3], 4'h0};
        end
    end

    // Single-cycle event outputs. Start pulses are launched from LOAD so they
    // line up with the first ACCESS cycle.
    always_ff @(posedge i_clk156m) begin
        if (!i_srst_n) begin
            o_ddr_rd_startp <= 1'b0;
            o_ddr_wr_startp <= 1'b0;
            o_ddr_endp      <= 1'b0;
            o_ctrl_endp     <= 1'b0;
            o_err_ovr       <= 1'b0;
            o_err_timeout   <= 1'b0;
            o_sp_start      <= 1'b0;
        end else begin
            o_ddr_rd_startp <= (state == LOAD) && !o_ddr_wxr;
            o_ddr_wr_startp <= (state == LOAD) && o_ddr_wxr;
            o_ddr_endp      <= wr_done;
            o_ctrl_endp     <= wr_done && desc_last && !skip_latched;
            o_err_ovr       <= ptr_ovr || (i_ctrl_startp && (state != IDLE));
            o_err_timeout   <= timeout_event;
            o_sp_start      <= i_rxfifo_rd_last;
        end
    end

    // Per-channel offset address, frame_time*offset then +base, modulo 2^32.
    always_ff @(posedge i_clk156m) begin
        if (!i_srst_n) begin
            for (int k = 0; k < NUM_RAM; k++) begin
                prod[k] <= '0;
            end
            o_ram_offset_addr <= '0;
        end else begin
            for (int k = 0; k < NUM_RAM; k++) begin
                prod[k] <= 32'(o_frame_time) * i_frame_offset[32*k +: 32];
                o_ram_offset_addr[32*k +: 32] <= prod[k] + i_ram_base[32*k +: 32];
            end
        end
    end

endmodule

// File: tb/tb_sp_if_ctrl_ddr_seq.sv
// ---------------------------------------------------------------------------
// tb_sp_if_ctrl_ddr_seq
// Directed bench for sp_if_ctrl_ddr_seq. A small order memory model with a
// two-cycle read latency feeds the sequencer; every expected value below is
// worked out by hand from the entry contents and cycle counts.
// ---------------------------------------------------------------------------
module tb_sp_if_ctrl_ddr_seq;

    localparam int NUM_RAM = 2;
    localparam int FRM_W   = 4;
    localparam int ORD_AW  = 2;
    localparam int RD_LAT  = 2;
    localparam int TO_W    = 4;

    logic                  i_clk156m;
    logic                  i_srst_n;
    logic [FRM_W-1:0]      i_frame_max;
    logic [NUM_RAM*32-1:0] i_frame_offset;
    logic [NUM_RAM*32-1:0] i_ram_base;
    logic                  i_ctrl_startp;
    logic                  i_skip_tx;
    logic                  i_sp_end;
    logic                  i_ddr_endp;
    logic                  i_rxfifo_rd_last;
    logic                  o_ord_rden;
    logic [ORD_AW-1:0]     o_ord_addr;
    logic [63:0]           i_ord_data;
    logic [FRM_W-1:0]      o_frame_time;
    logic [NUM_RAM*32-1:0] o_ram_offset_addr;
    logic                  o_ddr_wxr;
    logic [3:0]            o_ddr_area;
    logic [26:0]           o_ddr_addr;
    logic [31:0]           o_ddr_size;
    logic                  o_ddr_start;
    logic                  o_ddr_rd_startp;
    logic                  o_ddr_wr_startp;
    logic                  o_sp_start;
    logic                  o_ddr_endp;
    logic                  o_ctrl_endp;
    logic                  o_busy;
    logic                  o_err_timeout;
    logic                  o_err_ovr;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [4];
    logic [63:0] rd_pipe [2];

    sp_if_ctrl_ddr_seq #(
        .NUM_RAM (NUM_RAM),
        .FRM_W   (FRM_W),
        .ORD_AW  (ORD_AW),
        .RD_LAT  (RD_LAT),
        .TO_W    (TO_W)
    ) dut (
        .i_clk156m         (i_clk156m),
        .i_srst_n          (i_srst_n),
        .i_frame_max       (i_frame_max),
        .i_frame_offset    (i_frame_offset),
        .i_ram_base        (i_ram_base),
        .i_ctrl_startp     (i_ctrl_startp),
        .i_skip_tx         (i_skip_tx),
        .i_sp_end          (i_sp_end),
        .i_ddr_endp        (i_ddr_endp),
        .i_rxfifo_rd_last  (i_rxfifo_rd_last),
        .o_ord_rden        (o_ord_rden),
        .o_ord_addr        (o_ord_addr),
        .i_ord_data        (i_ord_data),
        .o_frame_time      (o_frame_time),
        .o_ram_offset_addr (o_ram_offset_addr),
        .o_ddr_wxr         (o_ddr_wxr),
        .o_ddr_area        (o_ddr_area),
        .o_ddr_addr        (o_ddr_addr),
        .o_ddr_size        (o_ddr_size),
        .o_ddr_start       (o_ddr_start),
        .o_ddr_rd_startp   (o_ddr_rd_startp),
        .o_ddr_wr_startp   (o_ddr_wr_startp),
        .o_sp_start        (o_sp_start),
        .o_ddr_endp        (o_ddr_endp),
        .o_ctrl_endp       (o_ctrl_endp),
        .o_busy            (o_busy),
        .o_err_timeout     (o_err_timeout),
        .o_err_ovr         (o_err_ovr)
    );

    initial i_clk156m = 1'b0;
    always #5 i_clk156m = ~i_clk156m;

    // Order memory: read issued with o_ord_rden, data valid two cycles later.
    always @(posedge i_clk156m) begin
        if (o_ord_rden) begin
            rd_pipe[0] <= mem[o_ord_addr];
        end
        rd_pipe[1] <= rd_pipe[0];
    end
    assign i_ord_data = rd_pipe[1];

    function automatic logic [63:0] mkEntry(input logic last, input logic wxr,
                                            input logic [3:0] area,
                                            input logic [26:0] addr,
                                            input logic [27:0] size);
        return {last, wxr, area, addr, size, 3'b000};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge i_clk156m);
            #1;
        end
    endtask

    // Holds the given pulses for one cycle, then returns #1 after the edge
    // that sampled them.
    task automatic applyStimulus(input logic start, input logic skip,
                                 input logic ddr_end, input logic sp_end);
        i_ctrl_startp = start;
        i_skip_tx     = skip;
        i_ddr_endp    = ddr_end;
        i_sp_end      = sp_end;
        waitCycles(1);
        i_ctrl_startp = 1'b0;
        i_ddr_endp    = 1'b0;
        i_sp_end      = 1'b0;
    endtask

    // Read entry {area 1, addr 0x40, size 4} then write-last entry {size 2}.
    task automatic runReadWrite(input logic skip, input logic [3:0] exp_frame,
                                input logic [31:0] exp_ch0, input logic [31:0] exp_ch1);
        mem[0] = mkEntry(1'b0, 1'b0, 4'd1, 27'h40, 28'd4);
        mem[1] = mkEntry(1'b1, 1'b1, 4'd0, 27'h0, 28'd2);
        applyStimulus(1'b1, skip, 1'b0, 1'b0);
        checkOutput("rw_rden", o_ord_rden, 1);
        checkOutput("rw_addr0", o_ord_addr, 0);
        checkOutput("rw_busy", o_busy, 1);
        checkOutput("rw_frame", o_frame_time, exp_frame);
        waitCycles(3);
        checkOutput("rw_size_rd", o_ddr_size, 32'h40);
        checkOutput("rw_area", o_ddr_area, 1);
        checkOutput("rw_daddr", o_ddr_addr, 27'h40);
        checkOutput("rw_start_pre", o_ddr_start, 0);
        checkOutput("rw_ch0", o_ram_offset_addr[31:0], exp_ch0);
        checkOutput("rw_ch1", o_ram_offset_addr[63:32], exp_ch1);
        waitCycles(1);
        checkOutput("rw_rd_startp", o_ddr_rd_startp, 1);
        checkOutput("rw_wr_startp0", o_ddr_wr_startp, 0);
        checkOutput("rw_start", o_ddr_start, 1);
        waitCycles(1);
        checkOutput("rw_rd_startp_off", o_ddr_rd_startp, 0);
        applyStimulus(1'b0, skip, 1'b1, 1'b0);
        checkOutput("rw_start_fall", o_ddr_start, 0);
        checkOutput("rw_no_endp_rd", o_ddr_endp, 0);
        applyStimulus(1'b0, skip, 1'b1, 1'b0);
        checkOutput("rw_endp_ignored", o_ddr_endp, 0);
        checkOutput("rw_spwait_rden", o_ord_rden, 0);
        applyStimulus(1'b0, skip, 1'b0, 1'b1);
        checkOutput("rw_refetch", o_ord_rden, 1);
        checkOutput("rw_addr1", o_ord_addr, 1);
        waitCycles(3);
        checkOutput("rw_wxr", o_ddr_wxr, 1);
        checkOutput("rw_size_wr", o_ddr_size, 32'h20);
        waitCycles(1);
        checkOutput("rw_wr_startp", o_ddr_wr_startp, 1);
        checkOutput("rw_rd_startp1", o_ddr_rd_startp, 0);
        applyStimulus(1'b0, skip, 1'b1, 1'b0);
        checkOutput("rw_ddr_endp", o_ddr_endp, 1);
        checkOutput("rw_ctrl_endp", o_ctrl_endp, skip ? 1'b0 : 1'b1);
        checkOutput("rw_busy_end", o_busy, 0);
        checkOutput("rw_start_end", o_ddr_start, 0);
        waitCycles(1);
        checkOutput("rw_ddr_endp_off", o_ddr_endp, 0);
        checkOutput("rw_ctrl_endp_off", o_ctrl_endp, 0);
    endtask

    task automatic runWriteLast(input logic [3:0] exp_frame,
                                input logic [31:0] exp_ch0, input logic [31:0] exp_ch1);
        mem[0] = mkEntry(1'b1, 1'b1, 4'd3, 27'h100, 28'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wl_frame", o_frame_time, exp_frame);
        waitCycles(4);
        checkOutput("wl_wr_startp", o_ddr_wr_startp, 1);
        checkOutput("wl_ch0", o_ram_offset_addr[31:0], exp_ch0);
        checkOutput("wl_ch1", o_ram_offset_addr[63:32], exp_ch1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("wl_ctrl_endp", o_ctrl_endp, 1);
        checkOutput("wl_busy", o_busy, 0);
    endtask

    logic [3:0]  wrap_frame [3] = '{4'd2, 4'd3, 4'd0};
    logic [31:0] wrap_ch0 [3]   = '{32'h1200, 32'h1300, 32'h1000};
    logic [31:0] wrap_ch1 [3]   = '{32'hD000_0000, 32'h9000_0000, 32'h5000_0000};

    initial begin
        int n;
        i_srst_n         = 1'b0;
        i_frame_max      = 4'd3;
        i_frame_offset   = {32'hC000_0000, 32'h0000_0100};
        i_ram_base       = {32'h5000_0000, 32'h0000_1000};
        i_ctrl_startp    = 1'b0;
        i_skip_tx        = 1'b0;
        i_sp_end         = 1'b0;
        i_ddr_endp       = 1'b0;
        i_rxfifo_rd_last = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        rd_pipe[0] = '0;
        rd_pipe[1] = '0;
        waitCycles(3);

        $display("[TB] reset values");
        checkOutput("rst_frame", o_frame_time, 3);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_start", o_ddr_start, 0);
        checkOutput("rst_rden", o_ord_rden, 0);
        checkOutput("rst_size", o_ddr_size, 0);
        checkOutput("rst_ram", o_ram_offset_addr, 0);
        checkOutput("rst_err", {o_err_ovr, o_err_timeout, o_ctrl_endp}, 0);
        i_srst_n = 1'b1;
        waitCycles(2);

        i_rxfifo_rd_last = 1'b1;
        waitCycles(1);
        i_rxfifo_rd_last = 1'b0;
        checkOutput("sp_start", o_sp_start, 1);
        waitCycles(1);
        checkOutput("sp_start_off", o_sp_start, 0);

        $display("[TB] read/write sequence, then with skip");
        runReadWrite(1'b0, 4'd0, 32'h1000, 32'h5000_0000);
        runReadWrite(1'b1, 4'd1, 32'h1100, 32'h1000_0000);

        $display("[TB] frame wrap");
        for (int i = 0; i < 3; i++) begin
            runWriteLast(wrap_frame[i], wrap_ch0[i], wrap_ch1[i]);
        end

        $display("[TB] start while busy");
        mem[0] = mkEntry(1'b1, 1'b1, 4'd0, 27'h0, 28'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_pulse", o_err_ovr, 1);
        checkOutput("ovr_frame", o_frame_time, 1);
        checkOutput("ovr_start", o_ddr_start, 1);
        waitCycles(1);
        checkOutput("ovr_pulse_off", o_err_ovr, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("ovr_ctrl_endp", o_ctrl_endp, 1);

        $display("[TB] watchdog");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(4);
        n = 0;
        while (o_ddr_start && n < 40) begin
            n++;
            waitCycles(1);
        end
        checkOutput("to_cycles", n, 15);
        checkOutput("to_pulse", o_err_timeout, 1);
        checkOutput("to_busy", o_busy, 0);
        checkOutput("to_no_endp", {o_ddr_endp, o_ctrl_endp}, 0);
        waitCycles(1);
        checkOutput("to_pulse_off", o_err_timeout, 0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("tie_frame", o_frame_time, 3);
        waitCycles(4);
        waitCycles(14);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("tie_endp", o_ddr_endp, 1);
        checkOutput("tie_no_to", o_err_timeout, 0);
        checkOutput("tie_ctrl", o_ctrl_endp, 1);

        $display("[TB] order table exhaustion");
        for (int i = 0; i < 4; i++) mem[i] = mkEntry(1'b0, 1'b1, 4'd0, 27'(i * 16), 28'(i + 1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ex_rden", o_ord_rden, 1);
            checkOutput("ex_addr", o_ord_addr, i);
            waitCycles(4);
            checkOutput("ex_size", o_ddr_size, (i + 1) * 16);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("ex_ovr", o_err_ovr, 1);
        checkOutput("ex_busy", o_busy, 0);
        checkOutput("ex_endp", o_ddr_endp, 1);
        checkOutput("ex_ctrl", o_ctrl_endp, 0);

        $display("[TB] reset in WAIT_SP");
        mem[0] = mkEntry(1'b0, 1'b0, 4'd2, 27'h123, 28'd5);
        mem[1] = mkEntry(1'b1, 1'b1, 4'd0, 27'h0, 28'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mr_busy_pre", o_busy, 1);
        i_srst_n = 1'b0;
        waitCycles(1);
        i_srst_n = 1'b1;
        checkOutput("mr_frame", o_frame_time, 3);
        checkOutput("mr_busy", o_busy, 0);
        checkOutput("mr_desc", {o_ddr_wxr, o_ddr_area, o_ddr_addr, o_ddr_size}, 0);
        checkOutput("mr_ram", o_ram_offset_addr, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("mr_spend_ign", {o_busy, o_ord_rden, o_ctrl_endp}, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("mr_frame0", o_frame_time, 0);
        checkOutput("mr_addr0", o_ord_addr, 0);
        waitCycles(3);
        checkOutput("mr_area", o_ddr_area, 2);
        checkOutput("mr_size", o_ddr_size, 32'h50);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("mr_addr1", o_ord_addr, 1);
        waitCycles(4);
        checkOutput("mr_wr_startp", o_ddr_wr_startp, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mr_ctrl_endp", o_ctrl_endp, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
